// File: rtl/data_memory_lsu.sv
// Data memory and load/store unit for the single-cycle RV32I core.
// Byte-lane stores, sign/zero-extended loads, sticky fault capture.
module data_memory_lsu #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [2:0]  funct3,
   output logic [31:0] read_data,
   output logic        misaligned,
   output logic        fault_sticky,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr,
   output logic [31:0] store_count
);

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [IDX_W-1:0] idx;
   logic [31:0]      word;
   logic [31:0]      shifted;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [31:0]      ld_val;

   logic             half_w;
   logic             word_w;
   logic             mis_c;
   logic             ld_ill;
   logic             st_ill;
   logic             ill;
   logic             fault;
   logic             commit;

   logic [3:0]       be;
   logic [31:0]      wdat;

   logic             sticky_q, sticky_d;
   logic [1:0]       cause_q, cause_d;
   logic [31:0]      faddr_q, faddr_d;
   logic [31:0]      cnt_q, cnt_d;

   logic             unused_addr;

   // Upper address bits fold away: the array wraps.
   assign idx         = address[IDX_W+1:2];
   assign unused_addr = ^address[31:IDX_W+2];
   assign word        = mem_q[idx];

   // Classify the access: width, alignment and funct3 legality.
   always_comb begin
      half_w = (funct3[1:0] == 2'b01);
      word_w = (funct3[1:0] == 2'b10);
      mis_c  = (half_w & address[0]) |
               (word_w & (|address[1:0]));
      ld_ill = (funct3 == 3'b011) |
               (funct3[2:1] == 2'b11);
      st_ill = funct3[2] | (&funct3[1:0]);
      ill    = (mem_read & ld_ill) |
               (mem_write & st_ill);
      fault  = (mem_read | mem_write) &
               (mis_c | ill);
      commit = mem_write & ~fault & ~rst;
   end

   assign misaligned = fault;

   // Lane extraction and extension of the pre-edge word.
   always_comb begin
      shifted = word >> {address[1:0], 3'b000};
      byte_v  = shifted[7:0];
      half_v  = address[1] ? word[31:16] : word[15:0];
      ld_val  = 32'h0;
      case (funct3)
         3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
         3'b001:  ld_val = {{16{half_v[15]}}, half_v};
         3'b010:  ld_val = word;
         3'b100:  ld_val = {24'h0, byte_v};
         3'b101:  ld_val = {16'h0, half_v};
         default: ld_val = 32'h0;
      endcase
      read_data = (mem_read & ~fault) ? ld_val : 32'h0;
   end

   // Byte enables and lane-replicated store data.
   always_comb begin
      be   = 4'b0000;
      wdat = 32'h0;
      case (funct3[1:0])
         2'b00: begin
            be   = 4'b0001 << address[1:0];
            wdat = {4{write_data[7:0]}};
         end
         2'b01: begin
            be   = address[1] ? 4'b1100 : 4'b0011;
            wdat = {2{write_data[15:0]}};
         end
         2'b10: begin
            be   = 4'b1111;
            wdat = write_data;
         end
         default: begin
            be   = 4'b0000;
            wdat = 32'h0;
         end
      endcase
   end

   // Merge enabled bytes into the addressed word; array is never reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wdat[8*b +: 8];
            end
         end
      end
   end

   // First fault wins; illegal funct3 outranks misalignment.
   always_comb begin
      sticky_d = sticky_q;
      cause_d  = cause_q;
      faddr_d  = faddr_q;
      cnt_d    = cnt_q;
      if (fault & ~sticky_q) begin
         sticky_d = 1'b1;
         cause_d  = ill ? 2'b10 : 2'b01;
         faddr_d  = address;
      end
      if (commit) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Fault and store-count registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
         cause_q  <= 2'b00;
         faddr_q  <= 32'h0;
         cnt_q    <= 32'h0;
      end else begin
         sticky_q <= sticky_d;
         cause_q  <= cause_d;
         faddr_q  <= faddr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign fault_sticky = sticky_q;
   assign fault_cause  = cause_q;
   assign fault_addr   = faddr_q;
   assign store_count  = cnt_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: directed vector table,
// then random traffic against a byte-level reference model.
module tb_data_memory_lsu;

   localparam int DEPTH = 1024;
   localparam int BYTES = DEPTH * 4;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  funct3;
   logic [31:0] read_data;
   logic        misaligned;
   logic        fault_sticky;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;
   logic [31:0] store_count;

   int checks = 0;
   int errors = 0;

   data_memory_lsu #(
      .DEPTH_WORDS(DEPTH),
      .IDX_W(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .address(address),
      .write_data(write_data),
      .mem_write(mem_write),
      .mem_read(mem_read),
      .funct3(funct3),
      .read_data(read_data),
      .misaligned(misaligned),
      .fault_sticky(fault_sticky),
      .fault_cause(fault_cause),
      .fault_addr(fault_addr),
      .store_count(store_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic        re;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        mis;
      logic        st;
      logic [1:0]  cause;
      logic [31:0] fa;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   // reference model state
   logic [7:0]  mb [64];
   logic        m_st;
   logic [1:0]  m_cause;
   logic [31:0] m_fa;
   logic [31:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic we, input logic re,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input logic mis, input logic st,
                               input logic [1:0] cause, input logic [31:0] fa,
                               input logic [31:0] cnt);
      vec_t v;
      v.rst = r; v.we = we; v.re = re; v.f3 = f3;
      v.addr = addr; v.wd = wd; v.rd = rd; v.mis = mis;
      v.st = st; v.cause = cause; v.fa = fa; v.cnt = cnt;
      return v;
   endfunction

   task automatic drive(input logic r, input logic we, input logic re,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      @(negedge clk);
      rst = r; mem_write = we; mem_read = re;
      funct3 = f3; address = a; write_data = wd;
      #1;
   endtask

   task automatic model_op(input logic r, input logic we, input logic re,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
      int size;
      int off;
      int base;
      bit misc, ldb, stb, flt, illg;
      logic [31:0] val;
      case (f3[1:0])
         2'd0: size = 1;
         2'd1: size = 2;
         2'd2: size = 4;
         default: size = 0;
      endcase
      off  = int'(a % 4);
      base = int'(a % BYTES);
      misc = (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
      ldb  = (f3 == 3) || (f3 == 6) || (f3 == 7);
      stb  = (f3 > 2);
      illg = (re && ldb) || (we && stb);
      flt  = (re || we) && (misc || illg);
      val  = 32'h0;
      if (re && !flt) begin
         for (int b = 0; b < size; b++) val |= 32'(mb[base + b]) << (8 * b);
         if (!f3[2] && size < 4 && val[8 * size - 1])
            val |= 32'hFFFF_FFFF << (8 * size);
      end
      drive(r, we, re, f3, a, wd);
      chk({tag, " read_data"}, read_data, val);
      chk({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, flt});
      @(posedge clk);
      if (r) begin
         m_st = 0; m_cause = 0; m_fa = 0; m_cnt = 0;
      end else begin
         if (flt && !m_st) begin
            m_st = 1; m_cause = illg ? 2'b10 : 2'b01; m_fa = a;
         end
         if (we && !flt) begin
            for (int b = 0; b < size; b++) mb[base + b] = wd[8 * b +: 8];
            m_cnt++;
         end
      end
      #1;
      chk({tag, " fault_sticky"}, {31'h0, fault_sticky}, {31'h0, m_st});
      chk({tag, " fault_cause"}, {30'h0, fault_cause}, {30'h0, m_cause});
      chk({tag, " fault_addr"}, fault_addr, m_fa);
      chk({tag, " store_count"}, store_count, m_cnt);
   endtask

   initial begin
      rst = 1'b1; mem_write = 0; mem_read = 0;
      funct3 = 0; address = 0; write_data = 0;

      //            rst we re f3 addr          wdata          rd            mis st cs fa     cnt
      vecs.push_back(mk(0,1,0,2,32'h10,  32'hDEADBEEF,32'h0,       0,0,0,0,     1));
      vecs.push_back(mk(0,0,1,2,32'h10,  32'h0,       32'hDEADBEEF,0,0,0,0,     1));
      vecs.push_back(mk(0,1,0,0,32'h13,  32'hFFFFFF7F,32'h0,       0,0,0,0,     2));
      vecs.push_back(mk(0,0,1,0,32'h13,  32'h0,       32'h0000007F,0,0,0,0,     2));
      vecs.push_back(mk(0,0,1,2,32'h10,  32'h0,       32'h7FADBEEF,0,0,0,0,     2));
      vecs.push_back(mk(0,0,1,4,32'h11,  32'h0,       32'h000000BE,0,0,0,0,     2));
      vecs.push_back(mk(0,0,1,0,32'h11,  32'h0,       32'hFFFFFFBE,0,0,0,0,     2));
      vecs.push_back(mk(0,1,0,2,32'h20,  32'hCAFEF00D,32'h0,       0,0,0,0,     3));
      vecs.push_back(mk(0,1,0,1,32'h22,  32'h12348001,32'h0,       0,0,0,0,     4));
      vecs.push_back(mk(0,0,1,1,32'h22,  32'h0,       32'hFFFF8001,0,0,0,0,     4));
      vecs.push_back(mk(0,0,1,5,32'h22,  32'h0,       32'h00008001,0,0,0,0,     4));
      vecs.push_back(mk(0,0,1,2,32'h20,  32'h0,       32'h8001F00D,0,0,0,0,     4));
      vecs.push_back(mk(0,0,1,1,32'h20,  32'h0,       32'hFFFFF00D,0,0,0,0,     4));
      vecs.push_back(mk(0,1,0,2,32'h04,  32'hA5A5A5A5,32'h0,       0,0,0,0,     5));
      vecs.push_back(mk(0,1,0,2,32'h06,  32'h11111111,32'h0,       1,1,1,32'h6, 5));
      vecs.push_back(mk(0,0,1,2,32'h04,  32'h0,       32'hA5A5A5A5,0,1,1,32'h6, 5));
      vecs.push_back(mk(0,0,1,1,32'h01,  32'h0,       32'h0,       1,1,1,32'h6, 5));
      vecs.push_back(mk(1,1,0,2,32'h10,  32'h99999999,32'h0,       0,0,0,0,     0));
      vecs.push_back(mk(0,0,1,2,32'h10,  32'h0,       32'h7FADBEEF,0,0,0,0,     0));
      vecs.push_back(mk(0,0,1,3,32'h30,  32'h0,       32'h0,       1,1,2,32'h30,0));
      vecs.push_back(mk(1,0,0,0,32'h0,   32'h0,       32'h0,       0,0,0,0,     0));
      vecs.push_back(mk(0,1,0,5,32'h21,  32'hFFFFFFFF,32'h0,       1,1,2,32'h21,0));
      vecs.push_back(mk(0,0,1,2,32'h20,  32'h0,       32'h8001F00D,0,1,2,32'h21,0));
      vecs.push_back(mk(1,0,0,0,32'h0,   32'h0,       32'h0,       0,0,0,0,     0));
      vecs.push_back(mk(0,1,0,2,32'h1008,32'h12345678,32'h0,       0,0,0,0,     1));
      vecs.push_back(mk(0,0,1,2,32'h08,  32'h0,       32'h12345678,0,0,0,0,     1));
      vecs.push_back(mk(0,1,1,2,32'h08,  32'hAAAA5555,32'h12345678,0,0,0,0,     2));
      vecs.push_back(mk(0,0,1,2,32'h08,  32'h0,       32'hAAAA5555,0,0,0,0,     2));
      vecs.push_back(mk(0,0,0,3,32'h03,  32'h0,       32'h0,       0,0,0,0,     2));
      vecs.push_back(mk(0,0,1,2,32'h02,  32'h0,       32'h0,       1,1,1,32'h2, 2));
      vecs.push_back(mk(0,1,0,0,32'h09,  32'h000000EE,32'h0,       0,1,1,32'h2, 3));
      vecs.push_back(mk(0,0,1,4,32'h09,  32'h0,       32'h000000EE,0,1,1,32'h2, 3));
      vecs.push_back(mk(0,0,1,2,32'h08,  32'h0,       32'hAAAAEE55,0,1,1,32'h2, 3));

      repeat (2) @(posedge clk);
      #1;
      chk("reset fault_sticky", {31'h0, fault_sticky}, 32'h0);
      chk("reset fault_cause", {30'h0, fault_cause}, 32'h0);
      chk("reset fault_addr", fault_addr, 32'h0);
      chk("reset store_count", store_count, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].re,
               vecs[i].f3, vecs[i].addr, vecs[i].wd);
         chk($sformatf("vec%0d read_data", i), read_data, vecs[i].rd);
         chk($sformatf("vec%0d misaligned", i), {31'h0, misaligned}, {31'h0, vecs[i].mis});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d fault_sticky", i), {31'h0, fault_sticky}, {31'h0, vecs[i].st});
         chk($sformatf("vec%0d fault_cause", i), {30'h0, fault_cause}, {30'h0, vecs[i].cause});
         chk($sformatf("vec%0d fault_addr", i), fault_addr, vecs[i].fa);
         chk($sformatf("vec%0d store_count", i), store_count, vecs[i].cnt);
      end

      // random phase: reset, seed the 16-word window, then mixed traffic
      m_st = 0; m_cause = 0; m_fa = 0; m_cnt = 0;
      model_op(1, 0, 0, 3'd0, 32'h0, 32'h0, "rnd reset");
      for (int w = 0; w < 16; w++)
         model_op(0, 1, 0, 3'd2, 32'(w * 4), $urandom, $sformatf("init%0d", w));
      for (int n = 0; n < 500; n++) begin
         logic [31:0] a;
         logic        r;
         a = ($urandom & 32'hFFFF_F000) |
             32'($urandom_range(0, 15) << 2) |
             32'($urandom_range(0, 3));
         r = ($urandom_range(0, 49) == 0);
         model_op(r, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                  a, $urandom, $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
